mem_scan_arbiter: RTL and testbench

Shares the single data-memory port between the pipeline's Memory stage and a quadrant pixel scanner. The scanner streams the 8-bit pixels of one selected image quadrant over a valid/ready interface. The block sits between the Memory stage and data RAM. It stalls the pipeline when the scanner wins the port, and a starvation guard bounds how long the scanner waits.

---
 rtl/mem_scan_arbiter_if.sv | 50 +++++
 rtl/mem_scan_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_scan_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_scan_arbiter_if.sv
// Bus bundle between the Memory stage, the quadrant pixel consumer, the data
// RAM and the arbiter that shares the single RAM port among them.
interface mem_scan_arbiter_if #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 19
) ();

   logic              cpu_req;
   logic              cpu_we;
   logic              cpu_byte;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_stall;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_rvalid;

   logic              scan_start;
   logic [3:0]        cuadrante;
   logic              scan_busy;
   logic              scan_done;

   logic              pix_valid;
   logic              pix_ready;
   logic [7:0]        pixel;
   logic              pix_last;

   logic              mem_en;
   logic              mem_we;
   logic              mem_byte;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
      input  scan_start, cuadrante, pix_ready, mem_rdata,
      output cpu_stall, cpu_rdata, cpu_rvalid,
      output scan_busy, scan_done, pix_valid, pixel, pix_last,
      output mem_en, mem_we, mem_byte, mem_addr, mem_wdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
      output scan_start, cuadrante, pix_ready, mem_rdata,
      input  cpu_stall, cpu_rdata, cpu_rvalid,
      input  scan_busy, scan_done, pix_valid, pixel, pix_last,
      input  mem_en, mem_we, mem_byte, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_scan_arbiter.sv
// Shares the data-RAM port between the pipeline Memory stage and a scanner
// that streams one 100x100 quadrant of the image, one byte per pixel.
// The CPU normally wins; a starvation counter forces the scanner through
// after STARVE_MAX lost cycles so the pixel stream keeps moving.
module mem_scan_arbiter #(
   parameter int ADDR_W     = 18,
   parameter int DATA_W     = 19,
   parameter int IMG_DIM    = 400,
   parameter int QUAD_DIM   = 100,
   parameter int IMG_BASE   = 0,
   parameter int STARVE_MAX = 4
) (
   input logic                clk,
   input logic                reset,
   mem_scan_arbiter_if.slave  bus
);

   localparam int XW = $clog2(QUAD_DIM);
   localparam int CW = $clog2(STARVE_MAX + 1);

   localparam logic [ADDR_W-1:0] BASE_ADDR       = ADDR_W'(IMG_BASE);
   localparam logic [ADDR_W-1:0] ROW_STRIDE      = ADDR_W'(IMG_DIM);
   localparam logic [ADDR_W-1:0] QUAD_ROW_STRIDE = ADDR_W'(QUAD_DIM * IMG_DIM);
   localparam logic [ADDR_W-1:0] QUAD_COL_STRIDE = ADDR_W'(QUAD_DIM);
   localparam logic [XW-1:0]     LAST_POS        = XW'(QUAD_DIM - 1);

   typedef enum logic [2:0] {IDLE, ADDR, WAIT, OUT, DONE} scanState_t;

   scanState_t        state;
   scanState_t        nextState;
   logic [3:0]        quadReg;
   logic [XW-1:0]     xPos;
   logic [XW-1:0]     yPos;
   logic [7:0]        pixelReg;
   logic [CW-1:0]     starveCnt;
   logic              cpuRvalid;
   logic [ADDR_W-1:0] scanAddr;
   logic              scanGrant;
   logic              cpuGrant;
   logic              atLast;
   logic              handshake;

   assign atLast    = (xPos == LAST_POS) && (yPos == LAST_POS);
   assign handshake = (state == OUT) && bus.pix_ready;

   // Scanner byte address: quadrant origin plus row-major offset inside it.
   always_comb begin
      scanAddr = BASE_ADDR
               + ADDR_W'(quadReg[3:2]) * QUAD_ROW_STRIDE
               + ADDR_W'(quadReg[1:0]) * QUAD_COL_STRIDE
               + ADDR_W'(yPos) * ROW_STRIDE
               + ADDR_W'(xPos);
   end

   // Same-cycle arbitration: CPU first unless the scanner has starved long enough.
   always_comb begin
      scanGrant = (state == ADDR) &&
                  (!bus.cpu_req || (starveCnt == CW'(STARVE_MAX)));
      cpuGrant  = bus.cpu_req && !scanGrant;
   end

   // Scanner state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= nextState;
   end

   // Scanner next-state logic; a start pulse only counts from IDLE.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (bus.scan_start) nextState = ADDR;
         ADDR:    if (scanGrant) nextState = WAIT;
         WAIT:    nextState = OUT;
         OUT:     if (handshake) nextState = atLast ? DONE : ADDR;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Quadrant latch, pixel capture and x/y walk through the quadrant.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         quadReg  <= '0;
         xPos     <= '0;
         yPos     <= '0;
         pixelReg <= '0;
      end else begin
         if (state == IDLE && bus.scan_start) begin
            quadReg <= bus.cuadrante;
            xPos    <= '0;
            yPos    <= '0;
         end
         if (state == WAIT) pixelReg <= bus.mem_rdata[7:0];
         if (handshake && !atLast) begin
            if (xPos == LAST_POS) begin
               xPos <= '0;
               yPos <= yPos + XW'(1);
            end else begin
               xPos <= xPos + XW'(1);
            end
         end
      end
   end

   // Counts consecutive lost arbitration cycles; never passes STARVE_MAX
   // because reaching it forces the grant that clears it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                          starveCnt <= '0;
      else if (state == IDLE || scanGrant) starveCnt <= '0;
      else if (state == ADDR)              starveCnt <= starveCnt + CW'(1);
   end

   // CPU read data arrives from the RAM one cycle after its grant.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cpuRvalid <= 1'b0;
      else        cpuRvalid <= cpuGrant && !bus.cpu_we;
   end

   // RAM port mux and the remaining status outputs.
   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_byte  = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (scanGrant) begin
         bus.mem_en   = 1'b1;
         bus.mem_byte = 1'b1;
         bus.mem_addr = scanAddr;
      end else if (cpuGrant) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = bus.cpu_we;
         bus.mem_byte  = bus.cpu_byte;
         bus.mem_addr  = bus.cpu_addr;
         bus.mem_wdata = bus.cpu_wdata;
      end
      bus.cpu_stall  = bus.cpu_req && !cpuGrant;
      bus.cpu_rvalid = cpuRvalid;
      bus.cpu_rdata  = cpuRvalid ? bus.mem_rdata : '0;
      bus.scan_busy  = (state != IDLE);
      bus.scan_done  = (state == DONE);
      bus.pix_valid  = (state == OUT);
      bus.pixel      = pixelReg;
      bus.pix_last   = (state == OUT) && atLast;
   end

endmodule

// File: tb/tb_mem_scan_arbiter.sv
// Directed self-checking bench for mem_scan_arbiter: CPU path, a full
// quadrant scan, starvation forcing, backpressure and reset mid-scan.
module tb_mem_scan_arbiter;

   localparam int ADDR_W = 18;
   localparam int DATA_W = 19;

   logic clk;
   logic reset;
   int   checkCount;
   int   errorCount;

   mem_scan_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_scan_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IMG_DIM(400), .QUAD_DIM(100),
      .IMG_BASE(0), .STARVE_MAX(4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM model: unwritten bytes read back as their address low byte.
   logic [DATA_W-1:0] ram [logic [ADDR_W-1:0]];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we)
            ram[bus.mem_addr] = bus.mem_byte ? DATA_W'(bus.mem_wdata[7:0]) : bus.mem_wdata;
         else
            bus.mem_rdata <= ram.exists(bus.mem_addr) ? ram[bus.mem_addr]
                                                      : DATA_W'(bus.mem_addr[7:0]);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic req, input logic we, input logic byteSz,
                                input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata);
      bus.cpu_req   = req;
      bus.cpu_we    = we;
      bus.cpu_byte  = byteSz;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [ADDR_W-1:0] addrs [10000];
   int nAddr, nPix, nRise, firstRise, secondRise, pixErr, addrErr;
   int lastCount, lastIdx, doneCount, cyc, bpErr, cpuAddrErr, hs, doneSeen;
   logic prevValid, timedOut;
   logic [7:0] pix0;
   logic [4:0] stallBits;
   logic [ADDR_W-1:0] expAddr;

   initial begin
      checkCount = 0;
      errorCount = 0;
      reset = 1'b0;
      bus.scan_start = 1'b0;
      bus.cuadrante  = 4'b0000;
      bus.pix_ready  = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstBusy",   32'(bus.scan_busy),  0);
      checkOutput("rstValid",  32'(bus.pix_valid),  0);
      checkOutput("rstMemEn",  32'(bus.mem_en),     0);
      checkOutput("rstRvalid", 32'(bus.cpu_rvalid), 0);
      checkOutput("rstStall",  32'(bus.cpu_stall),  0);
      checkOutput("rstDone",   32'(bus.scan_done),  0);
      checkOutput("rstPixel",  32'(bus.pixel),      0);
      checkOutput("rstLast",   32'(bus.pix_last),   0);
      reset = 1'b1;
      tick();

      // CPU write then read of address 10
      applyStimulus(1'b1, 1'b1, 1'b0, 18'd10, 19'h5A5A5);
      checkOutput("wrMemEn",  32'(bus.mem_en),    1);
      checkOutput("wrMemWe",  32'(bus.mem_we),    1);
      checkOutput("wrAddr",   32'(bus.mem_addr),  10);
      checkOutput("wrData",   32'(bus.mem_wdata), 32'h5A5A5);
      checkOutput("wrStall",  32'(bus.cpu_stall), 0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
      checkOutput("wrNoRvalid", 32'(bus.cpu_rvalid), 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 18'd10, '0);
      checkOutput("rdMemWe", 32'(bus.mem_we), 0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
      checkOutput("rdRvalid", 32'(bus.cpu_rvalid), 1);
      checkOutput("rdData",   32'(bus.cpu_rdata),  32'h5A5A5);
      tick();
      checkOutput("rdRvalidOnce", 32'(bus.cpu_rvalid), 0);

      // Full uncontended scan of quadrant row 1, column 1
      bus.cuadrante  = 4'b0101;
      bus.scan_start = 1'b1;
      bus.pix_ready  = 1'b1;
      tick();
      bus.scan_start = 1'b0;
      cyc = 1; nAddr = 0; nPix = 0; nRise = 0; firstRise = -1; secondRise = -1;
      pixErr = 0; lastCount = 0; lastIdx = -1; doneCount = 0; prevValid = 1'b0;
      pix0 = 8'h00; timedOut = 1'b1;
      while (cyc < 40000) begin
         if (bus.mem_en) begin
            if (nAddr < 10000) addrs[nAddr] = bus.mem_addr;
            nAddr++;
         end
         if (bus.pix_valid && !prevValid) begin
            if (nRise == 0) firstRise = cyc;
            else if (nRise == 1) secondRise = cyc;
            nRise++;
         end
         prevValid = bus.pix_valid;
         if (bus.pix_valid && bus.pix_ready) begin
            if (nPix == 0) pix0 = bus.pixel;
            if (nPix < nAddr && nPix < 10000 && bus.pixel != addrs[nPix][7:0]) pixErr++;
            if (bus.pix_last) begin
               lastCount++;
               lastIdx = nPix;
            end
            nPix++;
         end
         if (bus.scan_done) doneCount++;
         if (doneCount > 0 && !bus.scan_busy) begin
            timedOut = 1'b0;
            break;
         end
         tick();
         cyc++;
      end
      addrErr = 0;
      for (int k = 0; k < 10000; k++) begin
         expAddr = ADDR_W'(40100 + (k / 100) * 400 + (k % 100));
         if (addrs[k] !== expAddr) addrErr++;
      end
      checkOutput("scanTimeout", 32'(timedOut), 0);
      checkOutput("addr0",    32'(addrs[0]),    40100);
      checkOutput("addr1",    32'(addrs[1]),    40101);
      checkOutput("addr99",   32'(addrs[99]),   40199);
      checkOutput("addr100",  32'(addrs[100]),  40500);
      checkOutput("addrLast", 32'(addrs[9999]), 79799);
      checkOutput("addrCount", 32'(nAddr), 10000);
      checkOutput("addrSeq",  32'(addrErr), 0);
      checkOutput("pixCount", 32'(nPix), 10000);
      checkOutput("pixel0",   32'(pix0), 32'hA4);
      checkOutput("pixData",  32'(pixErr), 0);
      checkOutput("lastCount", 32'(lastCount), 1);
      checkOutput("lastIdx",  32'(lastIdx), 9999);
      checkOutput("doneCount", 32'(doneCount), 1);
      checkOutput("firstValid", 32'(firstRise), 3);
      checkOutput("secondValid", 32'(secondRise), 6);

      // Starvation: CPU holds the port while the scanner waits in ADDR
      bus.pix_ready  = 1'b0;
      bus.cuadrante  = 4'b0010;
      bus.scan_start = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 18'd20, '0);
      tick();
      bus.scan_start = 1'b0;
      cpuAddrErr = 0;
      stallBits = '0;
      for (int i = 1; i <= 5; i++) begin
         #1;
         stallBits[i-1] = bus.cpu_stall;
         if (i == 5) begin
            checkOutput("forcedAddr", 32'(bus.mem_addr), 200);
            checkOutput("forcedWe",   32'(bus.mem_we),   0);
            checkOutput("forcedByte", 32'(bus.mem_byte), 1);
         end else if (bus.mem_addr != 18'd20) begin
            cpuAddrErr++;
         end
         tick();
      end
      checkOutput("stallPattern", 32'(stallBits), 32'b10000);
      checkOutput("cpuWinsFirst", 32'(cpuAddrErr), 0);
      checkOutput("resumeStall", 32'(bus.cpu_stall), 0);
      checkOutput("resumeAddr",  32'(bus.mem_addr),  20);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

      // Backpressure: hold OUT for 10 cycles, then release for one pixel
      tick();
      bpErr = 0;
      for (int i = 0; i < 10; i++) begin
         if (!bus.pix_valid || bus.pixel != 8'hC8 || bus.mem_en) bpErr++;
         tick();
      end
      checkOutput("bpHold",  32'(bpErr), 0);
      checkOutput("bpPixel", 32'(bus.pixel), 32'hC8);
      bus.pix_ready = 1'b1;
      tick();
      bus.pix_ready = 1'b0;
      #1;
      checkOutput("bpNextEn",   32'(bus.mem_en),   1);
      checkOutput("bpNextAddr", 32'(bus.mem_addr), 201);
      tick();
      tick();
      checkOutput("bpNextValid", 32'(bus.pix_valid), 1);
      checkOutput("bpNextPixel", 32'(bus.pixel), 32'hC9);

      // Reset mid-scan once pixel 57 has been consumed
      bus.pix_ready = 1'b1;
      hs = 1;
      timedOut = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         if (bus.pix_valid && bus.pix_ready) hs++;
         if (hs >= 57) begin
            timedOut = 1'b0;
            break;
         end
         tick();
      end
      checkOutput("hsTimeout", 32'(timedOut), 0);
      tick();
      reset = 1'b0;
      #1;
      checkOutput("midRstBusy",  32'(bus.scan_busy), 0);
      checkOutput("midRstValid", 32'(bus.pix_valid), 0);
      checkOutput("midRstMemEn", 32'(bus.mem_en),    0);
      checkOutput("midRstPixel", 32'(bus.pixel),     0);
      checkOutput("midRstLast",  32'(bus.pix_last),  0);
      doneSeen = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus.scan_done) doneSeen++;
      end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus.scan_done || bus.scan_busy) doneSeen++;
      end
      checkOutput("midRstNoDone", 32'(doneSeen), 0);
      bus.cuadrante  = 4'b1111;
      bus.scan_start = 1'b1;
      tick();
      bus.scan_start = 1'b0;
      #1;
      checkOutput("q15MemEn", 32'(bus.mem_en),   1);
      checkOutput("q15Addr",  32'(bus.mem_addr), 120300);
      tick();
      tick();
      checkOutput("q15Valid", 32'(bus.pix_valid), 1);
      checkOutput("q15Pixel", 32'(bus.pixel), 32'hEC);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
